pdm_multi_recv: RTL and testbench

Parametrised multi-channel PDM microphone receiver. It generates one PDM bit clock with a runtime-programmable divider and samples CHANNELS shared data lines, each carrying a left/right microphone pair, entirely in the `clk` domain with no derived-clock flops. Each side's bits are deserialised into PACK-bit words, and all channels are presented together on a valid/ready output with sticky overrun detection. It sits between the board PDM pins and the decimation filter chain.

---
 rtl/pdm_multi_recv.sv | 121 ++++++++++++
 tb/tb_pdm_multi_recv.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_multi_recv.sv
// pdm_multi_recv: multi-channel PDM microphone receiver.
// Generates the PDM bit clock from clk with a programmable divider and samples
// every shared data line at the end of each clock phase: the low phase feeds the
// left microphone, the high phase the right one. Each side is deserialised into
// PACK-bit words (first bit received lands in the MSB). All channels are then
// presented together on a valid/ready port, with a sticky flag for dropped sets.
module pdm_multi_recv #(
   parameter int CHANNELS = 2,
   parameter int DIV_W    = 8,
   parameter int PACK     = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic [DIV_W-1:0]             div,
   input  logic [CHANNELS-1:0]          pdm_data,
   output logic                         pdm_clk,
   output logic [2*CHANNELS*PACK-1:0]   out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   input  logic                         overrun_clr,
   output logic                         overrun
);

   localparam int BCW = (PACK > 1) ? $clog2(PACK) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(PACK - 1);

   logic [CHANNELS-1:0]        sync_a;
   logic [CHANNELS-1:0]        sync_b;
   logic [DIV_W-1:0]           cnt;
   logic [BCW-1:0]             bit_cnt;
   logic [PACK-1:0]            l_sh [CHANNELS];
   logic [PACK-1:0]            r_sh [CHANNELS];
   logic                       strobe;
   logic                       complete;
   logic [2*CHANNELS*PACK-1:0] word_set;

   // Two-flop synchroniser on the asynchronous microphone data lines
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= pdm_data;
         sync_b <= sync_a;
      end
   end

   // Sample strobe fires at the end of each half-period; the word set is complete on the last right-side sample
   always_comb begin
      strobe   = enable && (cnt >= div);
      complete = strobe && pdm_clk && (bit_cnt == LAST_BIT);
   end

   // Assemble the outgoing word set, folding in the right-side bit being sampled this very cycle
   always_comb begin
      word_set = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         word_set[(2*c)*PACK +: PACK]   = l_sh[c];
         word_set[(2*c+1)*PACK +: PACK] = (r_sh[c] << 1) | PACK'(sync_b[c]);
      end
   end

   // Divider, bit clock, per-side shift registers and bit counter; disable flushes any partial word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pdm_clk <= 1'b0;
         cnt     <= '0;
         bit_cnt <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            l_sh[c] <= '0;
            r_sh[c] <= '0;
         end
      end else if (!enable) begin
         pdm_clk <= 1'b0;
         cnt     <= '0;
         bit_cnt <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            l_sh[c] <= '0;
            r_sh[c] <= '0;
         end
      end else if (strobe) begin
         pdm_clk <= ~pdm_clk;
         cnt     <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            if (!pdm_clk) begin
               l_sh[c] <= (l_sh[c] << 1) | PACK'(sync_b[c]);
            end else begin
               r_sh[c] <= (r_sh[c] << 1) | PACK'(sync_b[c]);
            end
         end
         if (pdm_clk) begin
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BCW'(1);
         end
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

   // Output register and handshake: load when the slot is free or being drained, otherwise drop and flag overrun
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (complete && (!out_valid || out_ready)) begin
            out_data  <= word_set;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (complete && out_valid && !out_ready) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pdm_multi_recv.sv
// tb_pdm_multi_recv: directed scoreboard bench for pdm_multi_recv (2 channels, 8-bit words).
// The driver presents each microphone bit right after the matching pdm_clk edge;
// expected word sets are queued as they are issued and a monitor compares them on
// every handshake.
module tb_pdm_multi_recv;

   localparam int CHANNELS = 2;
   localparam int DIV_W    = 8;
   localparam int PACK     = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [7:0]  div = 8'd3;
   logic [1:0]  pdm_data = 2'b00;
   logic        pdm_clk;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        overrun_clr = 1'b0;
   logic        overrun;

   int          total = 0;
   int          bad = 0;
   logic [31:0] sb [$];

   pdm_multi_recv #(
      .CHANNELS(CHANNELS),
      .DIV_W(DIV_W),
      .PACK(PACK)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .div(div),
      .pdm_data(pdm_data),
      .pdm_clk(pdm_clk),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .overrun_clr(overrun_clr),
      .overrun(overrun)
   );

   // Free-running system clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Wait (bounded) until pdm_clk reaches the given level, checked 1 ns after each clk edge
   task automatic waitPdm(input logic level);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (pdm_clk !== level && n < 200);
      if (pdm_clk !== level) begin
         total++;
         bad++;
         $display("[TB] FAIL wait_pdm_clk: got %b expected %b", pdm_clk, level);
      end
   endtask

   // Drive nbits of a word set MSB first: L bit during the low phase, R bit during the high phase
   task automatic applyStimulus(input logic [7:0] l0, input logic [7:0] r0,
                                input logic [7:0] l1, input logic [7:0] r1,
                                input int nbits, input bit rdyLast);
      for (int i = 0; i < nbits; i++) begin
         pdm_data = {l1[7-i], l0[7-i]};
         enable   = 1'b1;
         waitPdm(1'b1);
         pdm_data = {r1[7-i], r0[7-i]};
         if (rdyLast && i == nbits - 1) begin
            repeat (int'(div)) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         waitPdm(1'b0);
      end
   endtask

   // Monitor: every accepted word set is popped from the scoreboard and compared
   always @(negedge clk) begin : monitor
      logic [31:0] expw;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_word: got %h expected none", out_data);
         end else begin
            expw = sb.pop_front();
            checkOutput("word", out_data, expw);
         end
      end
   end

   // Global watchdog
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios
   initial begin
      logic seen;
      logic e;

      #1;
      checkOutput("rst_pdm_clk", pdm_clk, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_overrun", overrun, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Basic capture, two back-to-back sets with out_ready held high
      sb.push_back(32'h00FF3CA5);
      applyStimulus(8'hA5, 8'h3C, 8'hFF, 8'h00, 8, 1'b0);
      checkOutput("set1_valid", out_valid, 1);
      checkOutput("set1_data", out_data, 32'h00FF3CA5);
      sb.push_back(32'h78563412);
      applyStimulus(8'h12, 8'h34, 8'h56, 8'h78, 8, 1'b0);
      checkOutput("set2_valid", out_valid, 1);
      @(posedge clk);
      #1;
      checkOutput("valid_pulse_end", out_valid, 0);
      enable = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Backpressure: first set held, second dropped
      out_ready = 1'b0;
      sb.push_back(32'hF00F5AC3);
      applyStimulus(8'hC3, 8'h5A, 8'h0F, 8'hF0, 8, 1'b0);
      checkOutput("bp_first_valid", out_valid, 1);
      checkOutput("bp_first_overrun", overrun, 0);
      applyStimulus(8'h11, 8'h22, 8'h33, 8'h44, 8, 1'b0);
      checkOutput("bp_overrun_set", overrun, 1);
      checkOutput("bp_data_held", out_data, 32'hF00F5AC3);
      checkOutput("bp_valid_held", out_valid, 1);
      enable = 1'b0;
      overrun_clr = 1'b1;
      @(posedge clk);
      #1 overrun_clr = 1'b0;
      checkOutput("overrun_cleared", overrun, 0);
      checkOutput("valid_kept_after_clr", out_valid, 1);

      // Accept and complete on the same cycle
      sb.push_back(32'h18E77E81);
      applyStimulus(8'h81, 8'h7E, 8'hE7, 8'h18, 8, 1'b1);
      checkOutput("simul_valid", out_valid, 1);
      checkOutput("simul_overrun", overrun, 0);
      checkOutput("simul_data", out_data, 32'h18E77E81);

      // Enable drop after 5 bits, during a high phase
      applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 5, 1'b0);
      pdm_data = 2'b11;
      waitPdm(1'b1);
      enable = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("drop_pdm_clk_low", pdm_clk, 0);
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      checkOutput("drop_no_valid", seen, 0);
      sb.push_back(32'h500A6996);
      applyStimulus(8'h96, 8'h69, 8'h0A, 8'h50, 8, 1'b0);
      checkOutput("reenable_data", out_data, 32'h500A6996);
      enable = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Divider change from 7 to 2 while cnt is 5
      div = 8'd7;
      @(posedge clk);
      #1 enable = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         @(posedge clk);
         #1;
         e = (k < 6) ? 1'b0 : ((((k - 6) / 3) % 2) == 0);
         checkOutput($sformatf("div_k%0d", k), pdm_clk, e);
         if (k == 5) div = 8'd2;
      end

      // Asynchronous reset mid-period, pdm_clk currently high
      #2 rst = 1'b1;
      #1;
      checkOutput("arst_pdm_clk", pdm_clk, 0);
      checkOutput("arst_out_data", out_data, 0);
      checkOutput("arst_out_valid", out_valid, 0);
      checkOutput("arst_overrun", overrun, 0);
      div = 8'd3;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         e = ((k / 4) % 2) == 1;
         checkOutput($sformatf("period_k%0d", k), pdm_clk, e);
      end

      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
